activation_buffer: RTL and testbench

Downstream stage of the neuron array. Collects the signed accumulator results of one layer's neurons, one per `in_valid` pulse. Applies ReLU, a fixed arithmetic right shift and unsigned saturation to each result. Stores the requantized values in a flattened register vector that drives the next layer's `in_data` bus, and pulses `layer_done` once all `NUM_NEURONS` results have been captured.

---
 rtl/activation_buffer.sv | 100 ++++++++++
 tb/tb_activation_buffer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/activation_buffer.sv
// Collects one layer of signed neuron results, requantizes each (ReLU, arithmetic
// shift, unsigned saturation) and presents the layer as a flattened register vector.
module activation_buffer #(
    parameter int NUM_NEURONS = 32,
    parameter int WIDTH_IN    = 32,
    parameter int WIDTH_OUT   = 8,
    parameter int SHIFT       = 8,
    localparam int CW         = $clog2(NUM_NEURONS + 1)
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic signed [WIDTH_IN-1:0]       in_data,
    output logic [WIDTH_OUT*NUM_NEURONS-1:0] out_data,
    output logic                             out_valid,
    output logic                             layer_done,
    output logic                             busy,
    output logic                             drop_err,
    output logic [CW-1:0]                    count
);

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam logic signed [WIDTH_IN-1:0] SAT_MAX =
        signed'({{(WIDTH_IN-WIDTH_OUT+1){1'b0}}, {(WIDTH_OUT-1){1'b1}}});

    function automatic logic [WIDTH_OUT-1:0] requant(input logic signed [WIDTH_IN-1:0] x);
        logic signed [WIDTH_IN-1:0] s;
        logic [WIDTH_OUT-1:0]       r;
        s = x >>> SHIFT;
        if (x < 0)
            r = '0;
        else if (s > SAT_MAX)
            r = SAT_MAX[WIDTH_OUT-1:0];
        else
            r = s[WIDTH_OUT-1:0];
        return r;
    endfunction

    state_t               state, state_next;
    logic [WIDTH_OUT-1:0] act_buf [NUM_NEURONS];
    logic [WIDTH_OUT-1:0] act_p0;
    logic                 write_en, drop;

    assign act_p0   = requant(in_data);
    // start always wins over a same-cycle sample, so neither a write nor a drop occurs.
    assign write_en = (state == COLLECT) && in_valid && !start;
    assign drop     = (state != COLLECT) && in_valid && !start;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = COLLECT;
            COLLECT: begin
                if (start)
                    state_next = COLLECT;
                else if (in_valid && count == CW'(NUM_NEURONS - 1))
                    state_next = DONE;
            end
            DONE:    state_next = start ? COLLECT : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            count     <= '0;
            out_valid <= 1'b0;
            drop_err  <= 1'b0;
            for (int i = 0; i < NUM_NEURONS; i++) act_buf[i] <= '0;
        end else begin
            state <= state_next;
            if (start) begin
                count     <= '0;
                out_valid <= 1'b0;
                drop_err  <= 1'b0;
                for (int i = 0; i < NUM_NEURONS; i++) act_buf[i] <= '0;
            end else begin
                if (write_en) begin
                    for (int i = 0; i < NUM_NEURONS; i++)
                        if (count == CW'(i)) act_buf[i] <= act_p0;
                    count <= count + CW'(1);
                end
                if (state == DONE) out_valid <= 1'b1;
                if (drop) drop_err <= 1'b1;
            end
        end
    end

    // Output stage: everything below is a direct view of registered state.
    assign busy       = (state == COLLECT);
    assign layer_done = (state == DONE);

    for (genvar g = 0; g < NUM_NEURONS; g++) begin : g_out
        assign out_data[(g+1)*WIDTH_OUT-1 -: WIDTH_OUT] = act_buf[g];
    end

endmodule

// File: tb/tb_activation_buffer.sv
// Randomized scoreboard bench for activation_buffer with a 4-neuron layer.
module tb_activation_buffer;
    localparam int N  = 4;
    localparam int CW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset = 1'b0, start = 1'b0, in_valid = 1'b0;
    logic signed [31:0] in_data = '0;
    logic [8*N-1:0]    out_data;
    logic              out_valid, layer_done, busy, drop_err;
    logic [CW-1:0]     count;

    activation_buffer #(.NUM_NEURONS(N), .WIDTH_IN(32), .WIDTH_OUT(8), .SHIFT(8)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data),
        .out_data(out_data), .out_valid(out_valid), .layer_done(layer_done),
        .busy(busy), .drop_err(drop_err), .count(count)
    );

    always #5 clk = ~clk;

    int n_checks = 0, n_pass = 0, n_layer_done = 0;
    logic [8*N-1:0] sb[$];

    // Reference model, kept in terms of the layer-level behaviour.
    int m_elem[N];
    int m_cnt = 0;
    bit m_collect = 0, m_done = 0, m_ov = 0, m_drop = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int rq(input logic signed [31:0] x);
        longint v;
        v = x;
        if (v < 0) return 0;
        v = v / 256;
        return (v > 127) ? 127 : int'(v);
    endfunction

    function automatic logic [8*N-1:0] packed_model();
        logic [8*N-1:0] p;
        for (int i = 0; i < N; i++) p[i*8 +: 8] = 8'(m_elem[i]);
        return p;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < N; i++) m_elem[i] = 0;
        m_cnt = 0;
    endtask

    task automatic check_state(input string tag);
        chk({tag, ".count"}, 64'(count), 64'(m_cnt));
        chk({tag, ".busy"}, 64'(busy), 64'(m_collect));
        chk({tag, ".drop_err"}, 64'(drop_err), 64'(m_drop));
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
        chk({tag, ".layer_done"}, 64'(layer_done), 64'(m_done));
        chk({tag, ".out_data"}, 64'(out_data), 64'(packed_model()));
    endtask

    // One clock edge with the given inputs, then the model follows the same edge.
    task automatic step(input bit s, input bit v, input logic signed [31:0] d);
        bit was_done;
        start = s; in_valid = v; in_data = v ? d : $urandom;
        @(posedge clk); #1;
        start = 0; in_valid = 0;
        was_done = m_done;
        m_done = 0;
        if (s) begin
            model_clear();
            m_ov = 0; m_drop = 0; m_collect = 1;
        end else if (v) begin
            if (m_collect) begin
                m_elem[m_cnt] = rq(d);
                m_cnt++;
                if (m_cnt == N) begin
                    m_collect = 0; m_done = 1;
                    sb.push_back(packed_model());
                end
            end else m_drop = 1;
        end
        if (!s && was_done) m_ov = 1;
        check_state("step");
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1; reset = 0;
        model_clear();
        m_collect = 0; m_done = 0; m_ov = 0; m_drop = 0;
        check_state("reset");
    endtask

    task automatic send4(input logic signed [31:0] a, b, c, d, input int maxgap);
        logic signed [31:0] v[4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) repeat ($urandom_range(0, maxgap)) step(0, 0, 0);
            step(0, 1, v[i]);
        end
    endtask

    // Monitor: every layer_done pulse consumes one expected layer.
    always @(negedge clk) begin
        if (!reset && layer_done === 1'b1) begin
            n_layer_done++;
            if (sb.size() == 0) chk("mon.unexpected_layer_done", 64'(out_data), 64'hDEAD);
            else chk("mon.layer", 64'(out_data), 64'(sb.pop_front()));
        end
    end

    initial begin
        int ld0;
        do_reset();

        // Reset mid-collection with count = 2.
        step(1, 0, 0);
        step(0, 1, 32'sd5000);
        step(0, 1, 32'sd9000);
        chk("pre_reset.count", 64'(count), 64'd2);
        do_reset();
        chk("post_reset.out_data", 64'(out_data), 64'd0);

        // Requantization, back-to-back.
        ld0 = n_layer_done;
        step(1, 0, 0);
        send4(-32'sd300, 32'sd14848, 32'sd65536, 32'sd255, 0);
        step(0, 0, 0);
        chk("requant.out_data", 64'(out_data), 64'h00_7F_3A_00);
        chk("requant.one_done", 64'(n_layer_done - ld0), 64'd1);

        // Same values with gaps.
        step(1, 0, 0);
        send4(-32'sd300, 32'sd14848, 32'sd65536, 32'sd255, 5);
        step(0, 0, 0);
        chk("gapped.out_data", 64'(out_data), 64'h00_7F_3A_00);

        // Restart mid-layer.
        ld0 = n_layer_done;
        step(1, 0, 0);
        step(0, 1, 32'sd1024);
        step(0, 1, 32'sd2048);
        chk("restart.partial", 64'(out_data), 64'h00_00_08_04);
        step(1, 1, 32'sd4096);
        send4(32'sd512, 32'sd512, 32'sd512, 32'sd512, 1);
        step(0, 0, 0);
        chk("restart.out_data", 64'(out_data), 64'h02_02_02_02);
        chk("restart.one_done", 64'(n_layer_done - ld0), 64'd1);

        // Drop error behaviour.
        step(0, 1, 32'sd1000);
        chk("drop.set", 64'(drop_err), 64'd1);
        chk("drop.buffer_kept", 64'(out_data), 64'h02_02_02_02);
        step(1, 0, 0);
        chk("drop.cleared", 64'(drop_err), 64'd0);
        do_reset();
        step(1, 1, 32'sd1000);
        chk("drop.start_wins", 64'(drop_err), 64'd0);

        // Saturation edges.
        send4(32'sh7FFFFFFF, 32'sd32767, 32'sd32511, 32'sh80000000, 0);
        step(0, 0, 0);
        chk("sat.out_data", 64'(out_data), 64'h00_7E_7F_7F);

        // start during DONE.
        step(1, 0, 0);
        send4(32'sd256, 32'sd512, 32'sd768, 32'sd1024, 0);
        step(1, 0, 0);
        send4(32'sd2560, 32'sd0, -32'sd1, 32'sd40000, 2);
        step(0, 0, 0);

        // Randomized layers with restarts and stray samples.
        for (int l = 0; l < 40; l++) begin
            step(1, 0, 0);
            while (m_collect) begin
                if ($urandom_range(0, 19) == 0) step(1, $urandom_range(0, 1), $urandom);
                repeat ($urandom_range(0, 2)) step(0, 0, 0);
                case ($urandom_range(0, 2))
                    0:       step(0, 1, $urandom);
                    1:       step(0, 1, $urandom_range(0, 40000));
                    default: step(0, 1, -$urandom_range(0, 1000));
                endcase
            end
            repeat ($urandom_range(0, 3)) step(0, $urandom_range(0, 3) == 0, $urandom);
        end
        step(0, 0, 0);
        step(0, 0, 0);
        chk("sb.drained", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
